// File: rtl/endpoint_csr_if.sv
// Host CSR/cache bus between the host bridge (master) and endpoint_csr (slave).
// Zero-wait CSR responses; cache-window accesses hold while host_request_stall is high.
interface endpoint_csr_if;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ren;
    logic        host_wen;
    logic [3:0]  host_strobe;
    logic [31:0] host_rdata;
    logic        host_error;
    logic        host_request_stall;

    modport master (
        output host_addr, host_wdata, host_ren, host_wen, host_strobe,
        input  host_rdata, host_error, host_request_stall
    );

    modport slave (
        input  host_addr, host_wdata, host_ren, host_wen, host_strobe,
        output host_rdata, host_error, host_request_stall
    );
endinterface

// File: rtl/endpoint_csr.sv
// Endpoint CSRs, send-trigger queue, busy/IRQ tracking and TX-cache arbitration; CSRs zero-wait, irq +1 cycle.
// Host cache access yields to the internal reader for at most MAX_WAIT cycles; send queue drains on send_ready.
module endpoint_csr #(
    parameter int NUM_MSGS     = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int SEND_Q_DEPTH = 4,
    parameter int MAX_WAIT     = 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    endpoint_csr_if.slave                  host,
    input  logic                           i_int_ren,
    input  logic [ADDR_WIDTH-1:0]          i_int_addr,
    output logic [31:0]                    o_int_rdata,
    output logic                           o_int_stall,
    output logic                           o_mem_ren,
    output logic                           o_mem_wen,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [31:0]                    o_mem_wdata,
    output logic [3:0]                     o_mem_strobe,
    input  logic [31:0]                    i_mem_rdata,
    input  logic                           i_mem_stall,
    output logic                           o_send_valid,
    output logic [$clog2(NUM_MSGS)-1:0]    o_send_id,
    input  logic                           i_send_ready,
    input  logic                           i_send_done,
    input  logic [$clog2(NUM_MSGS)-1:0]    i_send_done_id,
    output logic [NUM_MSGS*ADDR_WIDTH-1:0] o_pkt_start_addr,
    input  logic                           i_crc_error,
    input  logic                           i_overflow,
    output logic                           o_irq
);
    localparam int ID_W = $clog2(NUM_MSGS);
    localparam int QP_W = $clog2(SEND_Q_DEPTH);
    localparam int QC_W = QP_W + 1;
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [31:0] A_SEND   = 32'h0000_1004;
    localparam logic [31:0] A_STATUS = 32'h0000_1008;
    localparam logic [31:0] A_IRQ_ST = 32'h0000_100C;
    localparam logic [31:0] A_IRQ_EN = 32'h0000_1010;
    localparam logic [31:0] WIN_BASE = 32'h0000_2000;
    localparam logic [31:0] BAD_DATA = 32'hBAD1_BAD1;

    logic [ADDR_WIDTH-1:0] r_pkt_start [NUM_MSGS];
    logic [ID_W-1:0]       r_q [SEND_Q_DEPTH];
    logic [QP_W-1:0]       r_wr_ptr;
    logic [QP_W-1:0]       r_rd_ptr;
    logic [QC_W-1:0]       r_count;
    logic [NUM_MSGS-1:0]   r_busy;
    logic [3:0]            r_irq_status;
    logic [3:0]            r_irq_en;
    logic                  r_irq;
    logic [WC_W-1:0]       r_wait_cnt;

    logic                  w_req, w_wr, w_rd;
    logic                  w_is_pkt, w_is_send, w_is_status, w_is_irq_st, w_is_irq_en, w_is_win;
    logic [ID_W-1:0]       w_pkt_idx;
    logic [ID_W-1:0]       w_send_id;
    logic                  w_send_wr, w_accept, w_reject, w_pop;
    logic                  w_q_full, w_q_empty;
    logic                  w_host_mem, w_host_grant, w_int_grant;
    logic [NUM_MSGS-1:0]   w_busy_nxt;
    logic [3:0]            w_irq_clr, w_irq_set;
    logic [31:0]           w_status;

    assign w_req       = host.host_ren | host.host_wen;
    assign w_wr        = host.host_wen;
    assign w_rd        = host.host_ren & ~host.host_wen;
    assign w_is_pkt    = ((host.host_addr >> (ID_W + 2)) == 32'd0) && (host.host_addr[1:0] == 2'b00);
    assign w_pkt_idx   = host.host_addr[ID_W+1:2];
    assign w_is_send   = (host.host_addr == A_SEND);
    assign w_is_status = (host.host_addr == A_STATUS);
    assign w_is_irq_st = (host.host_addr == A_IRQ_ST);
    assign w_is_irq_en = (host.host_addr == A_IRQ_EN);
    assign w_is_win    = ((host.host_addr >> ADDR_WIDTH) == (WIN_BASE >> ADDR_WIDTH));

    assign w_q_full  = (r_count == QC_W'(SEND_Q_DEPTH));
    assign w_q_empty = (r_count == '0);
    assign w_send_id = host.host_wdata[ID_W-1:0];
    assign w_send_wr = w_wr && w_is_send;
    // Acceptance is judged on pre-edge state, so a same-cycle send_done does not free the slot yet.
    assign w_accept  = w_send_wr && (host.host_wdata < 32'(NUM_MSGS)) && !r_busy[w_send_id] && !w_q_full;
    assign w_reject  = w_send_wr && !w_accept;
    assign w_pop     = o_send_valid && i_send_ready;

    assign o_send_valid = !w_q_empty;
    assign o_send_id    = r_q[r_rd_ptr];
    assign o_irq        = r_irq;

    assign host.host_error = w_req && (!(w_is_pkt || w_is_send || w_is_status || w_is_irq_st ||
                                         w_is_irq_en || w_is_win) ||
                                       (w_wr && w_is_status) || (w_rd && w_is_send) || w_reject);

    assign w_host_mem   = w_req && w_is_win;
    assign w_host_grant = w_host_mem && (!i_int_ren || (r_wait_cnt == WC_W'(MAX_WAIT)));
    assign w_int_grant  = i_int_ren && !w_host_grant;

    assign host.host_request_stall = (w_host_mem && !w_host_grant) || (w_host_grant && i_mem_stall);
    assign o_int_stall = (i_int_ren && w_host_grant) || (w_int_grant && i_mem_stall);
    assign o_int_rdata = w_int_grant ? i_mem_rdata : 32'd0;

    genvar g;
    generate
        for (g = 0; g < NUM_MSGS; g++) begin : g_pkt
            assign o_pkt_start_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_pkt_start[g];
        end
    endgenerate

    always_comb begin
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_strobe = '0;
        if (w_host_grant) begin
            o_mem_ren    = w_rd;
            o_mem_wen    = w_wr;
            o_mem_addr   = host.host_addr[ADDR_WIDTH-1:0];
            o_mem_wdata  = host.host_wdata;
            o_mem_strobe = host.host_strobe;
        end else if (i_int_ren) begin
            o_mem_ren  = 1'b1;
            o_mem_addr = i_int_addr;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[NUM_MSGS-1:0]   = r_busy;
        w_status[16]             = w_q_full;
        w_status[17]             = w_q_empty;
    end

    always_comb begin
        host.host_rdata = BAD_DATA;
        if (w_rd) begin
            if (w_is_pkt)          host.host_rdata = 32'(r_pkt_start[w_pkt_idx]);
            else if (w_is_status)  host.host_rdata = w_status;
            else if (w_is_irq_st)  host.host_rdata = 32'(r_irq_status);
            else if (w_is_irq_en)  host.host_rdata = 32'(r_irq_en);
            else if (w_host_grant) host.host_rdata = i_mem_rdata;
        end
    end

    // Clear before set: a send_done and an accepted SEND never target the same slot.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_send_done) w_busy_nxt[i_send_done_id] = 1'b0;
        if (w_accept)    w_busy_nxt[w_send_id] = 1'b1;
    end

    assign w_irq_clr = (w_wr && w_is_irq_st) ? host.host_wdata[3:0] : 4'd0;
    assign w_irq_set = {w_reject, i_send_done, i_overflow, i_crc_error};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_MSGS; i++) r_pkt_start[i] <= '0;
            for (int i = 0; i < SEND_Q_DEPTH; i++) r_q[i] <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_busy       <= '0;
            r_irq_status <= '0;
            r_irq_en     <= '0;
            r_irq        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            if (w_wr && w_is_pkt)
                r_pkt_start[w_pkt_idx] <= {host.host_wdata[ADDR_WIDTH-1:2], 2'b00};
            if (w_wr && w_is_irq_en)
                r_irq_en <= host.host_wdata[3:0];
            r_irq_status <= (r_irq_status & ~w_irq_clr) | w_irq_set;
            r_irq        <= |(r_irq_status & r_irq_en);
            r_busy       <= w_busy_nxt;
            if (w_accept) begin
                r_q[r_wr_ptr] <= w_send_id;
                r_wr_ptr      <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_host_mem && !w_host_grant)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
        end
    end
endmodule
